// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, coordinate type and helpers.
package vga_pkg;

    // Horizontal timing in pixels.
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    // Vertical timing in lines.
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    // Width of the coordinate counters.
    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    // Length of one scan period: visible area, front porch, sync pulse and back porch.
    function automatic int span_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    // First counter value of the sync pulse.
    function automatic int sync_start(input int visible, input int front);
        return visible + front;
    endfunction

    // Derived totals and sync start points.
    localparam int H_TOTAL  = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_START = sync_start(H_VISIBLE, H_FRONT);
    localparam int VS_START = sync_start(V_VISIBLE, V_FRONT);

endpackage

// File: rtl/vga_timing_generator_wrap_counter.sv
// Modulo-MAX counter that advances when en is high.
// The wrap output flags the enabled tick on which the count returns to zero.
module wrap_counter
    import vga_pkg::*;
#(
    parameter int MAX = H_TOTAL
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output logic   wrap
);

    localparam coord_t LAST = coord_t'(MAX - 1);

    coord_t count_q;
    coord_t count_d;

    // Next count: hold, increment, or return to zero after the last value.
    always_comb begin
        wrap    = en && (count_q == LAST);
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + coord_t'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA timing generator: one pixel every two clk cycles.
// Stage 0 presents the requested coordinate (x, y, visible) combinationally.
// Stage 1 registers sync, blanking and the returned colour one pixel tick later.
module vga_timing_generator #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [23:0]         rgb_in,
    output vga_pkg::coord_t     x,
    output vga_pkg::coord_t     y,
    output logic                visible,
    output logic                vga_clk,
    output logic [7:0]          vga_r,
    output logic [7:0]          vga_g,
    output logic [7:0]          vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_blank_n,
    output logic                vga_sync_n
);

    import vga_pkg::*;

    // Totals and sync windows come from the package helpers, so overriding a
    // timing parameter keeps every derived value consistent.
    localparam int H_TOT = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOT = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam coord_t H_VIS_C    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C    = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST_C = coord_t'(sync_start(H_VISIBLE, H_FRONT));
    localparam coord_t HS_END_C   = coord_t'(sync_start(H_VISIBLE, H_FRONT) + H_SYNC);
    localparam coord_t VS_FIRST_C = coord_t'(sync_start(V_VISIBLE, V_FRONT));
    localparam coord_t VS_END_C   = coord_t'(sync_start(V_VISIBLE, V_FRONT) + V_SYNC);

    logic        pix_en_q;
    logic        pix_en_d;
    coord_t      hcount;
    coord_t      vcount;
    logic        h_wrap;
    logic        v_wrap;
    logic        visible_s0;
    logic        hs_raw;
    logic        vs_raw;

    logic        hs_q;
    logic        hs_d;
    logic        vs_q;
    logic        vs_d;
    logic        blank_n_q;
    logic        blank_n_d;
    logic [23:0] rgb_q;
    logic [23:0] rgb_d;

    // Pixel enable alternates every clk; a pixel tick is an edge with pix_en_q high.
    always_comb begin
        pix_en_d = ~pix_en_q;
    end

    // Pixel enable register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_en_q <= 1'b0;
        end else begin
            pix_en_q <= pix_en_d;
        end
    end

    // Horizontal position; its wrap advances the line counter.
    wrap_counter #(
        .MAX(H_TOT)
    ) u_hcount (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en_q),
        .count(hcount),
        .wrap (h_wrap)
    );

    // Vertical position; wraps together with hcount on the last pixel of the frame.
    wrap_counter #(
        .MAX(V_TOT)
    ) u_vcount (
        .clk  (clk),
        .rst  (rst),
        .en   (h_wrap),
        .count(vcount),
        .wrap (v_wrap)
    );

    // Stage 0: visible-area compare and raw active-low sync windows.
    always_comb begin
        visible_s0 = (hcount < H_VIS_C) && (vcount < V_VIS_C);
        hs_raw     = !((hcount >= HS_FIRST_C) && (hcount < HS_END_C));
        vs_raw     = !((vcount >= VS_FIRST_C) && (vcount < VS_END_C));
    end

    // Stage 1 next values: capture on a pixel tick, colour forced to black when blanked.
    always_comb begin
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        rgb_d     = rgb_q;
        if (pix_en_q) begin
            hs_d      = hs_raw;
            vs_d      = vs_raw;
            blank_n_d = visible_s0;
            rgb_d     = visible_s0 ? rgb_in : 24'h000000;
        end
    end

    // Stage 1 output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= 24'h000000;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            rgb_q     <= rgb_d;
        end
    end

    // Stage 1 updates on the edge that drops pix_en_q, so vga_clk rises one clk
    // later, in the middle of the two-clk output interval.
    assign vga_clk     = pix_en_q;
    assign x           = hcount;
    assign y           = vcount;
    assign visible     = visible_s0;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a full-size instance and a shrunken one
// (32 x 22 total) share clock and reset. Each is checked every cycle against
// an arithmetic model based on the pixel index, plus literal timing expectations.
module tb_vga_timing_generator;

    // Shrunken timing for the frame-level instance.
    localparam int SHV = 16, SHF = 4, SHS = 8, SHB = 4;   // 32 pixels per line
    localparam int SVV = 12, SVF = 3, SVS = 2, SVB = 5;   // 22 lines per frame

    typedef struct {
        int          x;
        int          y;
        bit          vis;
        bit          vclk;
        bit          hs;
        bit          vs;
        bit          blank;
        logic [23:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] rgb_a = 24'h0;
    logic [23:0] rgb_b = 24'h0;

    logic [9:0]  x_a, y_a, x_b, y_b;
    logic        vis_a, vclk_a, hs_a, vs_a, blank_a, syncn_a;
    logic        vis_b, vclk_b, hs_b, vs_b, blank_b, syncn_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    int n = 0;              // clk edges since reset release
    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    bit phase1    = 1'b1;

    // Measurements over the first line / frame.
    int hs_low_a = 0, blank_hi_a = 0, first_hs_a = -1, line_end_a = -1;
    int vs_low_b = 0, first_vs_b = -1, frame_end_b = -1;

    vga_timing_generator u_dut_a (
        .clk(clk), .rst(rst), .rgb_in(rgb_a),
        .x(x_a), .y(y_a), .visible(vis_a), .vga_clk(vclk_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_blank_n(blank_a), .vga_sync_n(syncn_a)
    );

    vga_timing_generator #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) u_dut_b (
        .clk(clk), .rst(rst), .rgb_in(rgb_b),
        .x(x_b), .y(y_b), .visible(vis_b), .vga_clk(vclk_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank_n(blank_b), .vga_sync_n(syncn_b)
    );

    always #10 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            if (fail_cnt <= 30)
                $display("FAIL %s at n=%0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    // Colour the external layer logic returns for a coordinate.
    function automatic logic [23:0] pattern(input int hc, input int vc);
        logic [7:0] hl, vl, hq;
        if (hc == 0 && vc == 0) return 24'hff0000;
        if (hc == 700)          return 24'h00ff00;
        hl = 8'(hc);
        vl = 8'(vc);
        hq = 8'(hc >> 2);
        return {hl ^ 8'h5a, vl, hq};
    endfunction

    // Expected outputs after n edges: pixel index p = n/2; registered outputs
    // describe pixel p-1 (reset values before the first tick).
    function automatic exp_t model(input int nn, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb);
        exp_t e;
        int ht, vt, p, q, qh, qv;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        p  = nn / 2;
        e.x    = p % ht;
        e.y    = (p / ht) % vt;
        e.vis  = (e.x < hv) && (e.y < vv);
        e.vclk = (nn % 2) == 1;
        if (p == 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0; e.rgb = 24'h0;
        end else begin
            q  = p - 1;
            qh = q % ht;
            qv = (q / ht) % vt;
            e.hs    = !(qh >= hv + hf && qh < hv + hf + hsw);
            e.vs    = !(qv >= vv + vf && qv < vv + vf + vsw);
            e.blank = (qh < hv) && (qv < vv);
            e.rgb   = e.blank ? pattern(qh, qv) : 24'h0;
        end
        return e;
    endfunction

    task automatic compare_dut(input string tag, input exp_t e,
                               input logic [9:0] x, input logic [9:0] y, input logic vis,
                               input logic vclk, input logic hs, input logic vs,
                               input logic blank, input logic [23:0] rgb, input logic syncn);
        check({tag, ".x"}, 32'(x), 32'(e.x));
        check({tag, ".y"}, 32'(y), 32'(e.y));
        check({tag, ".visible"}, 32'(vis), 32'(e.vis));
        check({tag, ".vga_clk"}, 32'(vclk), 32'(e.vclk));
        check({tag, ".hs"}, 32'(hs), 32'(e.hs));
        check({tag, ".vs"}, 32'(vs), 32'(e.vs));
        check({tag, ".blank_n"}, 32'(blank), 32'(e.blank));
        check({tag, ".rgb"}, 32'(rgb), 32'(e.rgb));
        check({tag, ".sync_n"}, 32'(syncn), 32'd0);
    endtask

    // Per-cycle compare, first-line/frame measurements, and next colour drive.
    always @(negedge clk) begin
        exp_t ea, eb;
        ea = model(n, 640, 16, 96, 48, 480, 10, 2, 33);
        eb = model(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
        compare_dut("a", ea, x_a, y_a, vis_a, vclk_a, hs_a, vs_a, blank_a, {r_a, g_a, b_a}, syncn_a);
        compare_dut("b", eb, x_b, y_b, vis_b, vclk_b, hs_b, vs_b, blank_b, {r_b, g_b, b_b}, syncn_b);

        if (phase1 && !rst) begin
            if (n >= 2 && n <= 1601) begin
                if (!hs_a) hs_low_a++;
                if (blank_a) blank_hi_a++;
                if (!hs_a && first_hs_a < 0) first_hs_a = n;
            end
            if (n >= 2 && x_a == 10'd0 && line_end_a < 0) line_end_a = n;
            if (n >= 2 && n <= 1409) begin
                if (!vs_b) vs_low_b++;
                if (!vs_b && first_vs_b < 0) first_vs_b = n;
            end
            if (n >= 2 && x_b == 10'd0 && y_b == 10'd0 && frame_end_b < 0) frame_end_b = n;
            // Hand-computed pins.
            if (n == 2) begin
                check("lit_red_r", 32'(r_a), 32'hff);
                check("lit_red_g", 32'(g_a), 32'h0);
                check("lit_red_b", 32'(b_a), 32'h0);
            end
            if (n == 1402) check("lit_x700_rgb", 32'({r_a, g_a, b_a}), 32'h0);
            if (n == 1313) check("lit_hs_before", 32'(hs_a), 32'd1);
            if (n == 1407) begin
                check("lit_corner_x", 32'(x_b), 32'd31);
                check("lit_corner_y", 32'(y_b), 32'd21);
            end
            if (n == 1408) begin
                check("lit_wrap_x", 32'(x_b), 32'd0);
                check("lit_wrap_y", 32'(y_b), 32'd0);
                check("lit_wrap_vis", 32'(vis_b), 32'd1);
            end
        end

        rgb_a = pattern(ea.x, ea.y);
        rgb_b = pattern(eb.x, eb.y);
    end

    task automatic wait_n(input int target);
        int guard;
        guard = 0;
        while (n != target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_bound", 32'(n), 32'(target));
    endtask

    initial begin
        // Reset held for 5 clk.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_x", 32'(x_a), 32'd0);
        check("rst_y", 32'(y_a), 32'd0);
        check("rst_hs", 32'(hs_a), 32'd1);
        check("rst_vs", 32'(vs_a), 32'd1);
        check("rst_blank", 32'(blank_a), 32'd0);
        check("rst_rgb", 32'({r_a, g_a, b_a}), 32'd0);
        rst = 1'b0;
        $display("reset released");

        wait_n(2);
        check("lit_x_after_2", 32'(x_a), 32'd1);

        wait_n(1610);
        $display("line: hs_low=%0d blank_hi=%0d first_hs=%0d line_end=%0d",
                 hs_low_a, blank_hi_a, first_hs_a, line_end_a);
        check("line_hs_low_clk", 32'(hs_low_a), 32'd192);
        check("line_blank_hi_clk", 32'(blank_hi_a), 32'd1280);
        check("line_hs_first_n", 32'(first_hs_a), 32'd1314);
        check("line_len_clk", 32'(line_end_a), 32'd1600);
        check("frame_len_clk", 32'(frame_end_b), 32'd1408);
        check("frame_vs_low_clk", 32'(vs_low_b), 32'd128);
        check("frame_vs_first_n", 32'(first_vs_b), 32'd962);

        // Mid-frame reset at (300,2) on the full-size instance.
        wait_n(3800);
        check("pre_rst_x", 32'(x_a), 32'd300);
        check("pre_rst_y", 32'(y_a), 32'd2);
        check("pre_rst_bx", 32'(x_b), 32'd12);
        phase1 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_x", 32'(x_a), 32'd0);
        check("async_y", 32'(y_a), 32'd0);
        check("async_hs", 32'(hs_a), 32'd1);
        check("async_vs", 32'(vs_a), 32'd1);
        check("async_blank", 32'(blank_a), 32'd0);
        check("async_rgb", 32'({r_a, g_a, b_a}), 32'd0);
        check("async_vclk", 32'(vclk_a), 32'd0);
        check("async_bx", 32'(x_b), 32'd0);
        $display("mid-frame reset asserted");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        wait_n(2);
        check("restart_x", 32'(x_a), 32'd1);
        check("restart_y", 32'(y_a), 32'd0);
        wait_n(3000);
        $display("restart run done");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
